// File: rtl/cpu_regfile.sv
// SM83 register file with 8-bit ALU ports, CHNZ flag port and a 16-bit inc/dec unit.
// Optional debug port set (dbg_regs / dbg_halt) enabled by defining GB_REGFILE_DEBUG_EN.
module cpu_regfile #(
   parameter bit BOOT_SKIP = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  rd_a_sel,
   output logic [7:0]  rd_a_data,
   input  logic [3:0]  rd_b_sel,
   output logic [7:0]  rd_b_data,
   input  logic        wr_en,
   input  logic [3:0]  wr_sel,
   input  logic [7:0]  wr_data,
   input  logic        flag_wr_en,
   input  logic [3:0]  flag_wr_mask,
   input  logic [3:0]  flag_in,
   output logic [3:0]  flags_out,
   input  logic        idu_en,
   input  logic [2:0]  idu_pair,
   input  logic [1:0]  idu_op,
   output logic [15:0] idu_out,
   output logic [15:0] pc_out,
   output logic [15:0] sp_out,
   output logic [15:0] hl_out
`ifdef GB_REGFILE_DEBUG_EN
   ,
   output logic [111:0] dbg_regs,
   input  logic         dbg_halt
`endif
);

   localparam logic [3:0] IDX_F   = 4'd6;
   localparam logic [3:0] NUM_REG = 4'd14;

   // Packed element order (MSB first): Z W PCL PCH SPL SPH A F L H E D C B
   localparam logic [13:0][7:0] BOOT_VAL = {8'h00, 8'h00, 8'h00, 8'h01, 8'hFE, 8'hFF, 8'h01,
                                            8'hB0, 8'h4D, 8'h01, 8'hD8, 8'h00, 8'h13, 8'h00};
   localparam logic [13:0][7:0] RESET_VAL = BOOT_SKIP ? BOOT_VAL : '0;

   logic [13:0][7:0] rf;
   logic [13:0][7:0] rf_nxt;
   logic             halt;
   logic             pair_ok;
   logic [3:0]       pair_hi;
   logic [3:0]       pair_lo;
   logic [15:0]      pair_val;

`ifdef GB_REGFILE_DEBUG_EN
   assign halt     = dbg_halt;
   assign dbg_regs = {rf[7], rf[6], rf[0], rf[1], rf[2], rf[3], rf[4], rf[5],
                      rf[8], rf[9], rf[10], rf[11], rf[12], rf[13]};
`else
   assign halt = 1'b0;
`endif

   function automatic logic [3:0] hi_index(input logic [2:0] pair);
      case (pair)
         3'd0:    hi_index = 4'd0;
         3'd1:    hi_index = 4'd2;
         3'd2:    hi_index = 4'd4;
         3'd3:    hi_index = 4'd8;
         3'd4:    hi_index = 4'd10;
         3'd5:    hi_index = 4'd12;
         default: hi_index = 4'd0;
      endcase
   endfunction

   function automatic logic [15:0] idu_step(input logic [15:0] val, input logic [1:0] op);
      case (op)
         2'd1:    idu_step = val + 16'd1;
         2'd2:    idu_step = val - 16'd1;
         default: idu_step = val;
      endcase
   endfunction

   assign pair_ok  = (idu_pair <= 3'd5);
   assign pair_hi  = hi_index(idu_pair);
   assign pair_lo  = pair_hi + 4'd1;
   assign pair_val = {rf[pair_hi], rf[pair_lo]};
   assign idu_out  = pair_ok ? idu_step(pair_val, idu_op) : 16'h0000;

   assign rd_a_data = (rd_a_sel < NUM_REG) ? rf[rd_a_sel] : 8'h00;
   assign rd_b_data = (rd_b_sel < NUM_REG) ? rf[rd_b_sel] : 8'h00;
   assign flags_out = rf[IDX_F][7:4];
   assign pc_out    = {rf[10], rf[11]};
   assign sp_out    = {rf[8], rf[9]};
   assign hl_out    = {rf[4], rf[5]};

   // Later assignments take priority: IDU < 8-bit write < flag port on a shared byte/bit.
   always_comb begin
      rf_nxt = rf;
      if (!halt) begin
         if (idu_en && pair_ok) begin
            rf_nxt[pair_hi] = idu_out[15:8];
            rf_nxt[pair_lo] = idu_out[7:0];
         end
         if (wr_en && (wr_sel < NUM_REG)) begin
            rf_nxt[wr_sel] = wr_data;
         end
         if (flag_wr_en) begin
            for (int i = 0; i < 4; i++) begin
               if (flag_wr_mask[i]) begin
                  rf_nxt[IDX_F][4+i] = flag_in[i];
               end
            end
         end
      end
      rf_nxt[IDX_F][3:0] = 4'h0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rf <= RESET_VAL;
      end else begin
         rf <= rf_nxt;
      end
   end

endmodule
